serial_add_driver: RTL and testbench
====================================

SERIAL_ADD_DRIVER -- requirements
Module: serial_add_driver

Interface
REQ-001 Parameter N SHALL be: N, default 4, operand and result width in bits.
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port clr_n SHALL be: clr_n  input  1  asynchronous, active-low reset.
REQ-004 Port in_valid SHALL be: in_valid  input  1  op_a/op_b valid.
REQ-005 Port in_ready SHALL be: in_ready  output  1  driver able to accept operands.
REQ-006 Port op_a SHALL be: op_a  input  N  addend A.
REQ-007 Port op_b SHALL be: op_b  input  N  addend B.
REQ-008 Port ser_out SHALL be: ser_out  output  1  serial operand bit, LSB first, to the adder's serial_input.
REQ-009 Port shift_ctl SHALL be: shift_ctl  output  1  drives the adder's shift_control.
REQ-010 Port adder_clr SHALL be: adder_clr  output  1  drives the adder's synchronous carry clear (active-high).
REQ-011 Port sum_in SHALL be: sum_in  input  N  adder's parallel A-register output.
REQ-012 Port out_valid SHALL be: out_valid  output  1  sum_out valid.
REQ-013 Port out_ready SHALL be: out_ready  input  1  consumer accepts sum_out.
REQ-014 Port sum_out SHALL be: sum_out  output  N  captured result, (op_a+op_b) mod 2^N.

Function
REQ-015 FSM states SHALL be IDLE, INIT, LOAD_A, XFER, LOAD_B, ADD, FIN, RESP.
REQ-016 in_ready SHALL be 1 only in IDLE; a transfer occurs on an edge with in_valid&in_ready; op_a/op_b are latched then and IDLE->INIT.
REQ-017 INIT, LOAD_A, XFER, LOAD_B, ADD SHALL each last exactly N cycles, counted by a phase counter that wraps 0..N-1 and advances the state on N-1.
REQ-018 shift_ctl SHALL be 1 in INIT..ADD, 0 in IDLE, FIN, RESP.
REQ-019 ser_out SHALL be: INIT 0; LOAD_A latched A bit [count]; XFER 0; LOAD_B latched B bit [count]; ADD 0; otherwise 0.
REQ-020 adder_clr SHALL be 1 in INIT and FIN, 0 elsewhere.
REQ-021 In FIN, sum_out SHALL capture sum_in on the closing edge; state -> RESP, out_valid=1.
REQ-022 out_valid SHALL rise exactly 5N+1 edges after the accepting edge (21 for N=4).
REQ-023 In RESP, out_valid and sum_out SHALL hold stable until out_ready=1; that edge -> IDLE, out_valid=0.
REQ-024 in_valid while not in IDLE SHALL be ignored; operands are never overwritten mid-operation.
REQ-025 Addition SHALL wrap modulo 2^N; no carry-out is produced.

Reset
REQ-026 clr_n=0 SHALL immediately force state IDLE, phase counter 0, in_ready=1, out_valid=0, sum_out=0, ser_out=0, shift_ctl=0, adder_clr=0, latched operands 0, regardless of current state.
REQ-027 Reset mid-operation SHALL abandon the transaction with no out_valid; the next accepted transaction SHALL flush the adder via INIT.

Configuration
REQ-028 Macro SADRV_CHECK_EN SHALL, when defined, add output chk_err (1 bit) set in RESP if sum_out != (latched op_a + op_b) mod 2^N, cleared on leaving RESP and on reset.
REQ-029 Without SADRV_CHECK_EN, no chk_err port and no reference adder SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-030 Package sadrv_pkg SHALL hold the state enum type and phase-length constant derivation (counter width = clog2(N), min 1).
REQ-031 Sub-module sadrv_phase_cnt (wrapping 0..N-1 counter with enable, last-count flag) SHALL be used; all other logic stays in serial_add_driver.

Verification
REQ-032 N=4, op_a=3, op_b=5 -> ser_out LOAD_A bits 1,1,0,0, LOAD_B bits 1,0,1,0; out_valid at edge 21; sum_out=8.
REQ-033 op_a=15, op_b=1 -> sum_out=0 (wrap); op_a=0, op_b=0 -> sum_out=0.
REQ-034 out_ready held 0 for 10 cycles in RESP -> out_valid and sum_out stable; in_ready stays 0; single-cycle out_ready -> IDLE next edge.
REQ-035 clr_n pulsed low during ADD -> all outputs at reset values asynchronously; subsequent 6+7 -> sum_out=13.
REQ-036 in_valid toggled with op_a=9 during LOAD_B of a 2+2 transaction -> result 4, second operand set not consumed.
REQ-037 With SADRV_CHECK_EN, sum_in forced to 7 for 3+5 -> chk_err=1 in RESP; unforced -> chk_err=0.

Source files
------------

// File: rtl/sadrv_pkg.sv
// Shared types and sizing helpers for the serial adder driver.
package sadrv_pkg;

    // Driver sequencing: flush, shift A in, move it over, shift B in, add, capture, respond.
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD_A,
        S_XFER,
        S_LOAD_B,
        S_ADD,
        S_FIN,
        S_RESP
    } state_t;

    // Phase counter width: enough bits to count 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sadrv_phase_cnt.sv
// Wrapping 0..N-1 phase counter with enable and a last-count flag.
module sadrv_phase_cnt
    import sadrv_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = cnt_w(N)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    // Last count of a phase; the owner advances its state on this.
    always_comb begin
        last = (cnt == CW'(N - 1));
    end

    // Count while enabled, wrapping back to zero after the last count.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)      cnt <= '0;
        else if (en)     cnt <= last ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/serial_add_driver.sv
// Serial adder driver: accepts an operand pair, sequences a bit-serial adder
// through flush/load/add phases of N cycles each, and returns the captured sum.
// Optional build macro SADRV_CHECK_EN adds a chk_err output that compares the
// captured sum against a local reference adder.
module serial_add_driver
    import sadrv_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         ser_out,
    output logic         shift_ctl,
    output logic         adder_clr,
    input  logic [N-1:0] sum_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum_out
`ifdef SADRV_CHECK_EN
    ,
    output logic         chk_err
`endif
);

    localparam int CW = cnt_w(N);

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, b_q;
    logic [CW-1:0]  cnt;
    logic           last;

    // Phase counter runs only while the adder is being shifted.
    sadrv_phase_cnt #(.N(N), .CW(CW)) u_phase_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (shift_ctl),
        .cnt   (cnt),
        .last  (last)
    );

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and adder control; outputs decode from the state so reset clears them at once.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        shift_ctl = 1'b0;
        adder_clr = 1'b0;
        ser_out   = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_INIT;
            end
            S_INIT: begin
                shift_ctl = 1'b1;
                adder_clr = 1'b1;
                if (last) state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                shift_ctl = 1'b1;
                ser_out   = a_q[cnt];
                if (last) state_d = S_XFER;
            end
            S_XFER: begin
                shift_ctl = 1'b1;
                if (last) state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                shift_ctl = 1'b1;
                ser_out   = b_q[cnt];
                if (last) state_d = S_ADD;
            end
            S_ADD: begin
                shift_ctl = 1'b1;
                if (last) state_d = S_FIN;
            end
            S_FIN: begin
                adder_clr = 1'b1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operands are captured only on the accepting edge, so later in_valid cannot disturb them.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (state_q == S_IDLE && in_valid) begin
            a_q <= op_a;
            b_q <= op_b;
        end
    end

    // Result capture from the adder's parallel register at the end of FIN; held through RESP.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)                sum_out <= '0;
        else if (state_q == S_FIN) sum_out <= sum_in;
    end

`ifdef SADRV_CHECK_EN
    logic [N-1:0] ref_sum;

    // Reference sum, wrapping at N bits like the serial adder.
    always_comb begin
        ref_sum = a_q + b_q;
    end

    // Error flag evaluated on the same edge that captures sum_out, so it is valid for all of RESP.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)                                chk_err <= 1'b0;
        else if (state_q == S_FIN)                 chk_err <= (sum_in != ref_sum);
        else if (state_q == S_RESP && out_ready)   chk_err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_serial_add_driver.sv
// Directed bench for serial_add_driver (N=4) with a small serial adder stand-in.
module tb_serial_add_driver;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] op_a = '0;
    logic [N-1:0] op_b = '0;
    logic         ser_out;
    logic         shift_ctl;
    logic         adder_clr;
    logic [N-1:0] sum_in;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] sum_out;
`ifdef SADRV_CHECK_EN
    logic         chk_err;
`endif

    serial_add_driver #(.N(N)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .ser_out   (ser_out),
        .shift_ctl (shift_ctl),
        .adder_clr (adder_clr),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out)
`ifdef SADRV_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;

    // Adder stand-in: rebuilds A and B from the serial stream by shift-cycle position.
    int           k = 0;
    logic [N-1:0] ma = '0, mb = '0;
    logic         force_en = 1'b0;
    logic [N-1:0] force_val = '0;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) k <= 0;
        else if (shift_ctl) begin
            if (k >= N && k < 2*N)   ma[k-N]   <= ser_out;
            if (k >= 3*N && k < 4*N) mb[k-3*N] <= ser_out;
            k <= k + 1;
        end else k <= 0;
    end

    logic [N-1:0] model_sum;
    assign model_sum = ma + mb;
    assign sum_in    = force_en ? force_val : model_sum;

    int ntests = 0;
    int nfail  = 0;

    task automatic check(input string name, input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Per-sample record, sample s taken at the falling edge after rising edge s (edge 0 accepts).
    logic rec_ser[64];
    logic rec_sh[64];
    logic rec_clr[64];
    logic rec_rdy[64];

    task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic record(input int s);
        rec_ser[s] = ser_out;
        rec_sh[s]  = shift_ctl;
        rec_clr[s] = adder_clr;
        rec_rdy[s] = in_ready;
    endtask

    // Runs one transaction; lat is the sample index where out_valid first appears (-1 on timeout).
    task automatic run(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
        accept(a, b);
        lat = -1;
        for (int s = 0; s < 60; s++) begin
            record(s);
            if (out_valid) begin lat = s; break; end
            @(negedge clk);
        end
    endtask

    task automatic release_resp(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid after ready"}, int'(out_valid), 0);
        check({name, " in_ready after ready"}, int'(in_ready), 1);
    endtask

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   lat;
    logic [N-1:0] held;
    logic [N-1:0] ea, eb;

    initial begin
        vecs[0] = '{a: 4'd3,  b: 4'd5,  exp: 4'd8};
        vecs[1] = '{a: 4'd15, b: 4'd1,  exp: 4'd0};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  exp: 4'd0};
        vecs[3] = '{a: 4'd6,  b: 4'd7,  exp: 4'd13};
        vecs[4] = '{a: 4'd9,  b: 4'd9,  exp: 4'd2};
        vecs[5] = '{a: 4'd10, b: 4'd4,  exp: 4'd14};
        vecs[6] = '{a: 4'd15, b: 4'd15, exp: 4'd14};
        vecs[7] = '{a: 4'd7,  b: 4'd8,  exp: 4'd15};

        // Reset values while clr_n is held low.
        #12;
        check("rst in_ready",  int'(in_ready), 1);
        check("rst out_valid", int'(out_valid), 0);
        check("rst sum_out",   int'(sum_out), 0);
        check("rst ser_out",   int'(ser_out), 0);
        check("rst shift_ctl", int'(shift_ctl), 0);
        check("rst adder_clr", int'(adder_clr), 0);
        @(negedge clk);
        clr_n = 1'b1;

        // Table-driven transactions.
        foreach (vecs[i]) begin
            run(vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d latency", i), lat, 21);
            check($sformatf("vec%0d sum_out", i), int'(sum_out), int'(vecs[i].exp));
            release_resp($sformatf("vec%0d", i));
        end

        // 3+5: full control waveform, then hold RESP with out_ready low.
        ea = 4'd3; eb = 4'd5;
        run(ea, eb, lat);
        check("wave latency", lat, 21);
        for (int s = 0; s < 21; s++) begin
            logic es, eh, ec;
            eh = (s < 20);
            ec = (s < 4) || (s == 20);
            es = 1'b0;
            if (s >= 4 && s < 8)   es = ea[s-4];
            if (s >= 12 && s < 16) es = eb[s-12];
            check($sformatf("wave ser_out s%0d", s),   int'(rec_ser[s]), int'(es));
            check($sformatf("wave shift_ctl s%0d", s), int'(rec_sh[s]),  int'(eh));
            check($sformatf("wave adder_clr s%0d", s), int'(rec_clr[s]), int'(ec));
            check($sformatf("wave in_ready s%0d", s),  int'(rec_rdy[s]), 0);
        end
        check("wave sum_out", int'(sum_out), 8);
        held = sum_out;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("hold out_valid c%0d", c), int'(out_valid), 1);
            check($sformatf("hold sum_out c%0d", c),   int'(sum_out), int'(held));
            check($sformatf("hold in_ready c%0d", c),  int'(in_ready), 0);
        end
        release_resp("hold");

        // Asynchronous reset during ADD abandons the transaction.
        accept(4'd1, 4'd1);
        for (int s = 0; s < 18; s++) @(negedge clk);
        check("pre-rst shift_ctl", int'(shift_ctl), 1);
        #2 clr_n = 1'b0;
        #1;
        check("mid-rst in_ready",  int'(in_ready), 1);
        check("mid-rst out_valid", int'(out_valid), 0);
        check("mid-rst sum_out",   int'(sum_out), 0);
        check("mid-rst ser_out",   int'(ser_out), 0);
        check("mid-rst shift_ctl", int'(shift_ctl), 0);
        check("mid-rst adder_clr", int'(adder_clr), 0);
        @(negedge clk);
        clr_n = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (out_valid || shift_ctl) seen++;
            end
            check("post-rst idle", seen, 0);
        end
        run(4'd6, 4'd7, lat);
        check("post-rst latency", lat, 21);
        check("post-rst sum_out", int'(sum_out), 13);
        release_resp("post-rst");

        // in_valid with new operands during LOAD_B is ignored.
        accept(4'd2, 4'd2);
        lat = -1;
        for (int s = 0; s < 60; s++) begin
            if (s == 12) begin in_valid = 1'b1; op_a = 4'd9; op_b = 4'd9; end
            if (s == 16) in_valid = 1'b0;
            if (out_valid) begin lat = s; break; end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("ignore latency", lat, 21);
        check("ignore sum_out", int'(sum_out), 4);
        release_resp("ignore");
        begin
            int seen = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (shift_ctl || !in_ready) seen++;
            end
            check("ignore not consumed", seen, 0);
        end

`ifdef SADRV_CHECK_EN
        // Corrupted adder result must raise chk_err; a correct one must not.
        force_en = 1'b1; force_val = 4'd7;
        run(4'd3, 4'd5, lat);
        check("chk forced sum_out", int'(sum_out), 7);
        check("chk forced chk_err", int'(chk_err), 1);
        release_resp("chk forced");
        check("chk cleared", int'(chk_err), 0);
        force_en = 1'b0;
        run(4'd3, 4'd5, lat);
        check("chk clean chk_err", int'(chk_err), 0);
        release_resp("chk clean");
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    // Hard stop so a stuck run still ends with a summary.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        nfail++;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
